// File: rtl/spi_master_fifo.sv
// rtl/spi_master_fifo.sv - SPI master with TX/RX FIFOs, four SPI modes and multiple slave selects
//
// Purpose: register-bus SPI master. Words written to BUFFER queue in the TX FIFO and are
// shifted out back-to-back while enabled; received words queue in the RX FIFO.
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   addr_i      register address (0 CONFIG, 1 CTRL, 2 BUFFER, 3 SSELEC, 4 LEVEL)
//   wr_i        write strobe, one cycle per write
//   rd_i        read strobe; pops the RX FIFO when addr_i selects BUFFER
//   data_wr_i   write data
//   data_rd_o   combinational read data of the addressed register
//   sck_o       SPI clock
//   mosi_o      master data out
//   miso_i      master data in
//   ss_o        active-low slave selects
//   irq_o       level interrupt
module spi_master_fifo #(
  parameter int DATA_W     = 32,
  parameter int NUM_SS     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRE_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [2:0]        addr_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [31:0]       data_wr_i,
  output logic [31:0]       data_rd_o,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_SS-1:0] ss_o,
  output logic              irq_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CFG_W = PRE_W + 4;
  localparam int BW    = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_e;

  // Register file
  logic [CFG_W-1:0]  cfg_q;
  logic              en_q, irq_en_q, ovf_q;
  logic [NUM_SS-1:0] ssel_q;

  logic [PRE_W-1:0] cfg_pre;
  logic             cfg_cpha, cfg_cpol, cfg_lsb, cfg_auto_ss;
  assign cfg_pre     = cfg_q[PRE_W-1:0];
  assign cfg_cpha    = cfg_q[PRE_W];
  assign cfg_cpol    = cfg_q[PRE_W+1];
  assign cfg_lsb     = cfg_q[PRE_W+2];
  assign cfg_auto_ss = cfg_q[PRE_W+3];

  logic wr_cfg, wr_ctrl, wr_buf, wr_ssel, rd_buf;
  assign wr_cfg  = wr_i && (addr_i == 3'd0);
  assign wr_ctrl = wr_i && (addr_i == 3'd1);
  assign wr_buf  = wr_i && (addr_i == 3'd2);
  assign wr_ssel = wr_i && (addr_i == 3'd3);
  assign rd_buf  = rd_i && (addr_i == 3'd2);

  logic unused_wr_bits;
  assign unused_wr_bits = ^data_wr_i;

  // FIFO storage
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0]     tx_cnt_q, rx_cnt_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // Engine state
  state_e            state_q;
  logic [PRE_W-1:0]  hcnt_q, pre_q;
  logic              cpha_q, lsb_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              lead_edge_q;  // next XFER edge is a leading one
  logic              sck_q, mosi_q;

  logic busy, half_done;
  assign busy      = (state_q != S_IDLE);
  assign half_done = (hcnt_q == '0);

  logic tx_pop, tx_push, rx_pop, rx_push_req, rx_push;
  assign tx_pop      = (state_q == S_IDLE) && en_q && !tx_empty;
  // A push into a full TX FIFO is accepted when the engine frees a slot in the same cycle.
  assign tx_push     = wr_buf && (!tx_full || tx_pop);
  assign rx_pop      = rd_buf && !rx_empty;
  assign rx_push_req = (state_q == S_TRAIL) && half_done;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  logic [DATA_W-1:0] tx_head;
  logic              ld_bit, tx_bit;
  logic [DATA_W-1:0] ld_shift, tx_shift;
  assign tx_head  = tx_mem_q[tx_rp_q];
  assign ld_bit   = cfg_lsb ? tx_head[0] : tx_head[DATA_W-1];
  assign ld_shift = cfg_lsb ? (tx_head >> 1) : (tx_head << 1);
  assign tx_bit   = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
  assign tx_shift = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);

  // Registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q    <= '0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      ssel_q   <= '1;
    end else begin
      if (wr_cfg)  cfg_q  <= data_wr_i[CFG_W-1:0];
      if (wr_ssel) ssel_q <= data_wr_i[NUM_SS-1:0];
      if (wr_ctrl) begin
        en_q     <= data_wr_i[0];
        irq_en_q <= data_wr_i[1];
      end
      // A new overflow in the same cycle as the clear wins so the event is not lost.
      if (rx_push_req && rx_full && !rx_pop) ovf_q <= 1'b1;
      else if (wr_ctrl && data_wr_i[12])     ovf_q <= 1'b0;
    end
  end

  // FIFO pointers and counts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= data_wr_i[DATA_W-1:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
  end

  // Transfer engine
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      pre_q       <= '0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      lead_edge_q <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mosi_q <= 1'b0;
          if (tx_pop) begin
            state_q     <= S_LEAD;
            hcnt_q      <= cfg_pre;
            pre_q       <= cfg_pre;
            cpha_q      <= cfg_cpha;
            lsb_q       <= cfg_lsb;
            // sck_q carries the latched polarity for the whole word.
            sck_q       <= cfg_cpol;
            bit_cnt_q   <= BW'(DATA_W);
            lead_edge_q <= 1'b1;
            if (cfg_cpha) begin
              tx_sh_q <= tx_head;
            end else begin
              // cpha=0: the first bit must be valid before the first (sampling) edge.
              tx_sh_q <= ld_shift;
              mosi_q  <= ld_bit;
            end
          end
        end
        S_LEAD: begin
          if (half_done) begin
            state_q <= S_XFER;
            hcnt_q  <= pre_q;
          end else begin
            hcnt_q <= hcnt_q - PRE_W'(1);
          end
        end
        S_XFER: begin
          if (half_done) begin
            hcnt_q      <= pre_q;
            sck_q       <= ~sck_q;
            lead_edge_q <= ~lead_edge_q;
            // Shift edge: trailing for cpha=0, leading for cpha=1; the other edge samples.
            if (lead_edge_q == cpha_q) begin
              mosi_q  <= tx_bit;
              tx_sh_q <= tx_shift;
            end else if (lsb_q) begin
              rx_sh_q <= {miso_i, rx_sh_q[DATA_W-1:1]};
            end else begin
              rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso_i};
            end
            if (!lead_edge_q) begin
              bit_cnt_q <= bit_cnt_q - BW'(1);
              if (bit_cnt_q == BW'(1)) state_q <= S_TRAIL;
            end
          end else begin
            hcnt_q <= hcnt_q - PRE_W'(1);
          end
        end
        S_TRAIL: begin
          if (half_done) begin
            state_q <= S_IDLE;
            mosi_q  <= 1'b0;
          end else begin
            hcnt_q <= hcnt_q - PRE_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs
  assign sck_o  = busy ? sck_q : cfg_cpol;
  assign mosi_o = mosi_q;
  assign ss_o   = (cfg_auto_ss && !busy) ? '1 : ssel_q;
  assign irq_o  = irq_en_q & (!rx_empty | ovf_q);

  always_comb begin
    data_rd_o = '0;
    case (addr_i)
      3'd0: data_rd_o[CFG_W-1:0] = cfg_q;
      3'd1: data_rd_o[12:0] = {ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy,
                               5'b0, irq_en_q, en_q};
      3'd2: if (!rx_empty) data_rd_o[DATA_W-1:0] = rx_mem_q[rx_rp_q];
      3'd3: data_rd_o[NUM_SS-1:0] = ssel_q;
      3'd4: begin
        data_rd_o[7:0]  = 8'(tx_cnt_q);
        data_rd_o[15:8] = 8'(rx_cnt_q);
      end
      default: data_rd_o = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// tb/tb_spi_master_fifo.sv - self-checking bench for spi_master_fifo
module tb_spi_master_fifo;

  logic        clk, rst_n;
  logic [2:0]  addr;
  logic        wr, rd;
  logic [31:0] data_wr, data_rd;
  logic        sck, mosi, miso;
  logic [7:0]  ss;
  logic        irq;

  spi_master_fifo #(.DATA_W(32), .NUM_SS(8), .FIFO_DEPTH(4), .PRE_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wr_i(wr), .rd_i(rd),
    .data_wr_i(data_wr), .data_rd_o(data_rd), .sck_o(sck), .mosi_o(mosi),
    .miso_i(miso), .ss_o(ss), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model and MOSI scoreboard
  logic [31:0] exp_mosi[$];
  logic [31:0] slave_word;
  logic [31:0] cap;
  bit          slave_on, s_cpol, s_cpha, s_lsb;
  int          ecount, words_seen, dir_bad, mon_pos, miso_pos;

  assign miso_pos = (s_cpha == 1'b0) ? (ecount / 2) : ((ecount == 0) ? 0 : (ecount - 1) / 2);
  assign miso = slave_on & (s_lsb ? slave_word[miso_pos] : slave_word[31 - miso_pos]);

  always @(sck) begin
    if (slave_on) begin
      if (((ecount % 2) == 0) == (s_cpha == 1'b0)) begin
        mon_pos = ecount / 2;
        cap[s_lsb ? mon_pos : 31 - mon_pos] = mosi;
        if (sck !== ((s_cpha == s_cpol) ? 1'b1 : 1'b0)) dir_bad++;
      end
      ecount++;
      if (ecount == 64) begin
        ecount = 0;
        words_seen++;
        if (exp_mosi.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mosi_word: got unexpected word %h expected none", cap);
        end else begin
          check("mosi_word", cap, exp_mosi.pop_front());
        end
      end
    end
  end

  task automatic slave_setup(input bit cpol, input bit cpha, input bit lsb, input logic [31:0] w);
    s_cpol = cpol; s_cpha = cpha; s_lsb = lsb; slave_word = w;
    ecount = 0; slave_on = 1'b1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; data_wr = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); addr = a;
    #1 d = data_rd;
  endtask

  task automatic rx_pop(output logic [31:0] d);
    @(negedge clk); addr = 3'd2; rd = 1'b1;
    #1 d = data_rd;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input bit accept);
    reg_wr(3'd2, d);
    if (accept) exp_mosi.push_back(d);
  endtask

  // Polls CTRL once per cycle starting in the cycle after the triggering write (index 1)
  // until n busy periods have ended.
  task automatic run_xfers(input int n, input logic [7:0] ss_busy, input logic [7:0] ss_idle,
                           output int first_busy, output int busy_cnt, output int max_gap,
                           output int done_idx, output bit rx_ne, output int ss_bad);
    int falls, gap;
    bit prev, b;
    first_busy = 0; busy_cnt = 0; max_gap = 0; done_idx = 0; rx_ne = 1'b0; ss_bad = 0;
    falls = 0; gap = 0; prev = 1'b0;
    addr = 3'd1;
    #1;
    for (int k = 1; k <= 3000 && falls < n; k++) begin
      if (k > 1) begin
        @(negedge clk);
        #1;
      end
      b = data_rd[7];
      if (ss !== (b ? ss_busy : ss_idle)) ss_bad++;
      if (b) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = k;
        if (!prev && falls > 0 && gap > max_gap) max_gap = gap;
      end else if (prev) begin
        falls++;
        done_idx = k;
        rx_ne = !data_rd[11];
        gap = 1;
      end else begin
        gap++;
      end
      prev = b;
    end
    if (falls < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_xfers_timeout: saw %0d words expected %0d", falls, n);
    end
  endtask

  typedef struct {
    bit          do_wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int fb, bc, mg, di, sb;
    bit rne;

    vecs[0]  = '{1'b0, 3'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,        32'h0000_0A00};
    vecs[2]  = '{1'b0, 3'd2, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 3'd3, 32'h0,        32'h0000_00FF};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0FFF};
    vecs[7]  = '{1'b1, 3'd0, 32'h0000_05A3, 32'h0000_05A3};
    vecs[8]  = '{1'b1, 3'd3, 32'h0000_1234, 32'h0000_0034};
    vecs[9]  = '{1'b1, 3'd1, 32'h0000_0F03, 32'h0000_0A03};
    vecs[10] = '{1'b1, 3'd1, 32'h0000_0000, 32'h0000_0A00};
    vecs[11] = '{1'b1, 3'd7, 32'h0000_FFFF, 32'h0};
    vecs[12] = '{1'b1, 3'd0, 32'h0000_0000, 32'h0};
    vecs[13] = '{1'b1, 3'd3, 32'h0000_00FF, 32'h0000_00FF};

    addr = 3'd0; wr = 1'b0; rd = 1'b0; data_wr = '0; rst_n = 1'b0;
    slave_on = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; slave_word = '0;
    ecount = 0; words_seen = 0; dir_bad = 0; cap = '0;
    repeat (3) @(negedge clk);
    check("reset_sck", {31'b0, sck}, 32'h0);
    check("reset_mosi", {31'b0, mosi}, 32'h0);
    check("reset_ss", {24'b0, ss}, 32'hFF);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) reg_wr(vecs[i].addr, vecs[i].wdata);
      reg_rd(vecs[i].addr, d);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
    end

    // Mode 0, pre=2, single word
    reg_wr(3'd0, 32'h0000_0002);
    reg_wr(3'd3, 32'h0000_00FE);
    slave_setup(1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5);
    push_word(32'h0000_0301, 1'b1);
    reg_wr(3'd1, 32'h0000_0001);
    run_xfers(1, 8'hFE, 8'hFE, fb, bc, mg, di, rne, sb);
    check("m0_first_busy", fb, 2);
    check("m0_busy_cycles", bc, 198);
    check("m0_done_index", di, 200);
    check("m0_rx_visible", {31'b0, rne}, 32'h1);
    check("m0_ss", sb, 0);
    rx_pop(d);
    check("m0_rx_data", d, 32'hA5A5_A5A5);

    // Mode 3, LSB first, pre=1
    slave_on = 1'b0;
    reg_wr(3'd0, 32'h0000_0701);
    #1 check("m3_sck_idle_high", {31'b0, sck}, 32'h1);
    slave_setup(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    push_word(32'h8000_0001, 1'b1);
    run_xfers(1, 8'hFE, 8'hFE, fb, bc, mg, di, rne, sb);
    check("m3_busy_cycles", bc, 132);
    rx_pop(d);
    check("m3_rx_data", d, 32'h1234_5678);
    #1 check("m3_sck_back_high", {31'b0, sck}, 32'h1);

    // TX full drop and back-to-back words
    slave_on = 1'b0;
    reg_wr(3'd1, 32'h0);
    reg_wr(3'd0, 32'h0);
    slave_setup(1'b0, 1'b0, 1'b0, 32'h3C3C_5AA5);
    for (int i = 0; i < 5; i++) push_word(32'h1111_0000 + i, (i < 4));
    reg_rd(3'd4, d);
    check("b2b_tx_level", d, 32'h0000_0004);
    reg_wr(3'd1, 32'h0000_0001);
    run_xfers(4, 8'hFE, 8'hFE, fb, bc, mg, di, rne, sb);
    check("b2b_busy_cycles", bc, 264);
    check("b2b_gap", mg, 1);
    reg_rd(3'd4, d);
    check("b2b_rx_level", d, 32'h0000_0400);
    for (int i = 0; i < 4; i++) begin
      rx_pop(d);
      check($sformatf("b2b_rx%0d", i), d, 32'h3C3C_5AA5);
    end
    reg_rd(3'd4, d);
    check("b2b_level_empty", d, 32'h0);

    // RX overflow
    reg_wr(3'd1, 32'h0000_0002);
    slave_setup(1'b0, 1'b0, 1'b0, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) push_word(32'h2222_0000 + i, 1'b1);
    reg_wr(3'd1, 32'h0000_0003);
    run_xfers(4, 8'hFE, 8'hFE, fb, bc, mg, di, rne, sb);
    check("ovf_irq_rx", {31'b0, irq}, 32'h1);
    slave_word = 32'hDEAD_BEEF;
    push_word(32'h3333_3333, 1'b1);
    run_xfers(1, 8'hFE, 8'hFE, fb, bc, mg, di, rne, sb);
    reg_rd(3'd1, d);
    check("ovf_ctrl", d, 32'h0000_1603);
    reg_rd(3'd4, d);
    check("ovf_level", d, 32'h0000_0400);
    for (int i = 0; i < 4; i++) begin
      rx_pop(d);
      check($sformatf("ovf_rx%0d", i), d, 32'hCAFE_0001);
    end
    #1 check("ovf_irq_sticky", {31'b0, irq}, 32'h1);
    reg_wr(3'd1, 32'h0000_1003);
    reg_rd(3'd1, d);
    check("ovf_cleared", d, 32'h0000_0A03);
    check("ovf_irq_clear", {31'b0, irq}, 32'h0);

    // Automatic slave select
    slave_on = 1'b0;
    reg_wr(3'd0, 32'h0000_0800);
    reg_wr(3'd3, 32'h0000_00FB);
    slave_setup(1'b0, 1'b0, 1'b0, 32'h0F0F_F0F0);
    #1 check("auto_ss_idle", {24'b0, ss}, 32'hFF);
    push_word(32'h5555_AAAA, 1'b1);
    run_xfers(1, 8'hFB, 8'hFF, fb, bc, mg, di, rne, sb);
    check("auto_ss_track", sb, 0);
    rx_pop(d);
    check("auto_ss_rx", d, 32'h0F0F_F0F0);
    reg_wr(3'd0, 32'h0);
    #1 check("man_ss_idle", {24'b0, ss}, 32'hFB);
    push_word(32'h0123_4567, 1'b1);
    run_xfers(1, 8'hFB, 8'hFB, fb, bc, mg, di, rne, sb);
    check("man_ss_track", sb, 0);
    rx_pop(d);
    check("man_ss_rx", d, 32'h0F0F_F0F0);

    check("words_seen", words_seen, 13);
    check("mosi_queue_drained", exp_mosi.size(), 0);
    check("sample_edge_dir", dir_bad, 0);

    // Asynchronous reset mid-transfer
    reg_wr(3'd0, 32'h0000_0203);
    slave_setup(1'b1, 1'b0, 1'b0, 32'h7777_7777);
    push_word(32'hAAAA_5555, 1'b0);
    push_word(32'h5A5A_A5A5, 1'b0);
    repeat (20) @(negedge clk);
    addr = 3'd1;
    #1 check("rst_pre_busy", {31'b0, data_rd[7]}, 32'h1);
    slave_on = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_sck", {31'b0, sck}, 32'h0);
    check("rst_ss", {24'b0, ss}, 32'hFF);
    check("rst_mosi", {31'b0, mosi}, 32'h0);
    check("rst_ctrl", data_rd, 32'h0000_0A00);
    addr = 3'd4;
    #1 check("rst_level", data_rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_mosi.delete();
    repeat (2) @(negedge clk);
    #1 check("rst_still_idle", {24'b0, ss}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_fifo.md
# spi_master_fifo

Parametrised SPI master with TX/RX FIFOs, all four SPI modes, selectable bit order and multiple slave selects. It replaces the single-buffer bench/SoC SPI master behind the same register-bus style (Addr/Wr/DataWr/DataRd) and drives the SoC SPI slave or external flash. Transfers of DATA_W bits run back-to-back from the TX FIFO without CPU intervention, and received words queue in the RX FIFO.

## Interface
- DATA_W, 32: word length in bits (8..32).
- NUM_SS, 8: number of active-low slave-select outputs (1..8).
- FIFO_DEPTH, 4: TX and RX FIFO depth, a power of two ≥2.
- PRE_W, 8: prescaler field width.

- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Addr  in  3  register address.
- Wr  in  1  write strobe, one cycle per write.
- Rd  in  1  read strobe; pops RX only when Addr=2.
- DataWr  in  32  write data.
- DataRd  out  32  combinational read of register at Addr.
- Sck  out  1  SPI clock.
- Mosi  out  1  master data out.
- Miso  in  1  master data in.
- Ss  out  NUM_SS  active-low slave selects.
- Irq  out  1  level interrupt.

## Operation
- Register map. Unused and read-only bits read 0.
  - 0 CONFIG, reset 0: [PRE_W-1:0] pre, [PRE_W] cpha, [PRE_W+1] cpol, [PRE_W+2] lsb_first, [PRE_W+3] auto_ss.
  - 1 CTRL: bit0 en, bit1 irq_en (both R/W, reset 0). Read-only: bit7 busy, bit8 tx_full, bit9 tx_empty, bit10 rx_full, bit11 rx_empty. bit12 rx_ovf is sticky; writing 1 to bit12 clears it.
  - 2 BUFFER: a write pushes DataWr[DATA_W-1:0] to TX; the write is dropped if TX is full. A read returns the RX head zero-extended, or 0 if RX is empty. Rd at Addr=2 pops RX; a pop on empty is ignored.
  - 3 SSELEC: [NUM_SS-1:0], reset all 1s.
  - 4 LEVEL: [7:0] TX count, [15:8] RX count.
- Ss output:
  - auto_ss=0: Ss = SSELEC.
  - auto_ss=1: Ss = SSELEC while busy, all 1s otherwise.
- FSM states are IDLE, LEAD, XFER and TRAIL.
  - IDLE → LEAD when en=1 and TX is not empty. On this transition: pop TX into the shift register; latch pre, cpha, cpol and lsb_first (CONFIG writes during a transfer affect only the next word); load bit counter = DATA_W.
  - LEAD lasts one half-period with Sck=cpol, then goes to XFER.
  - XFER lasts 2·DATA_W half-periods. Sck toggles at the end of each half-period.
    - cpha=0: sample Miso on odd (leading) edges; shift Mosi on even (trailing) edges. The first bit is driven on entry to LEAD.
    - cpha=1: shift Mosi on leading edges; sample on trailing edges.
    - Bit order is MSB first, or LSB first if lsb_first=1.
  - TRAIL lasts one half-period with Sck=cpol. In its last cycle the received word is pushed to RX. If RX is full, the word is discarded and rx_ovf is set. Then go to IDLE.
- Half-period = pre+1 Clk cycles. pre=0 is legal and gives Sck = Clk/2.
- busy = 1 in LEAD, XFER and TRAIL.
- Mosi = 0 in IDLE. Sck = cpol (live CONFIG value) in IDLE.
- Clearing en mid-transfer finishes the current word, then the FSM stays in IDLE.
- Simultaneous push and pop on a full or empty FIFO: both take effect and the count is unchanged. A CPU push while the engine pops a full TX FIFO is accepted.
- Irq = irq_en & (!rx_empty | rx_ovf).

## Timing
- Reset values: DataRd per Addr with registers at reset; Sck=0, Mosi=0, Ss all 1s, Irq=0, FSM in IDLE, FIFOs empty.
- Per word: 1 cycle in IDLE, then (2·DATA_W+2)·(pre+1) cycles in LEAD/XFER/TRAIL.
- busy rises the cycle after the IDLE decision.
- RX data is visible (rx_empty=0) the cycle after the last TRAIL cycle; busy=0 in that same cycle.
- Back-to-back words: consecutive words are separated by exactly 1 IDLE cycle. Ss stays low across that cycle only when auto_ss=0.
- Register writes take effect on the next Clk edge.
- An asynchronous Rst_n assertion mid-transfer immediately forces all reset values and empties both FIFOs.

## Test plan
- Mode 0, pre=2, DATA_W=32, SSELEC=0xFE, slave model returns 0xA5A5A5A5. Write 0x00000301 to BUFFER, set en → Mosi carries 0x00000301 MSB first, Ss[0] low, transfer takes 1+66·3 = 199 cycles, RX reads 0xA5A5A5A5, busy returns to 0.
- Mode 3 (cpol=1, cpha=1), lsb_first=1, word 0x80000001 → Sck idles high; Mosi bit sequence is 1, 0×30, 1; sampling occurs on rising edges.
- Push 5 words with en=0 → LEVEL TX count = 4 and the 5th word is dropped. Then set en → 4 transfers with 1-cycle gaps; RX count = 4.
- Leave RX full and send one more word → rx_ovf=1, Irq=1 with irq_en set, RX contents unchanged. Writing CTRL bit12=1 clears rx_ovf.
- auto_ss=1, SSELEC=0xFB → Ss=0xFF in idle, 0xFB only while busy. With auto_ss=0 → Ss=0xFB constantly.
- Assert Rst_n low mid-XFER → Sck=0, Ss=0xFF, FIFOs empty, CTRL reads 0x0A00 (tx_empty and rx_empty set).
